// File: rtl/rvcore_bus_pkg.sv
// Shared types and constants for the core's memory-bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rvcore_bus_pkg;

  localparam int unsigned BUS_AW      = 32;
  localparam int unsigned BUS_DW      = 32;
  localparam int unsigned STRB_W      = 4;
  localparam int unsigned DEF_TIMEOUT = 255;
  localparam int unsigned DEF_CNT_W   = 8;

  // Arbiter state: idle, or which requester currently owns the bus.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_FETCH = 2'd2
  } bus_state_e;

  // One latched bus command; held stable for the whole access.
  typedef struct packed {
    logic              we;
    logic [BUS_AW-1:0] addr;
    logic [BUS_DW-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } bus_cmd_t;

  // Fetches are plain reads: no strobes, no write data.
  function automatic bus_cmd_t fetch_cmd(input logic [BUS_AW-1:0] addr);
    bus_cmd_t c;
    c.we    = 1'b0;
    c.addr  = addr;
    c.wdata = '0;
    c.wstrb = '0;
    return c;
  endfunction

endpackage

// File: rtl/bus_timeout_cnt.sv
// Counts wait cycles of a granted bus access and flags the abort cycle.
// Latency: o_tc is combinational in the cycle whose increment would reach TIMEOUT.
// Backpressure: none; counter simply holds when not enabled.
module bus_timeout_cnt #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tc;

  // Terminal count: this waiting cycle is the TIMEOUT-th one without an ack.
  always_comb begin
    tc    = i_en & (cnt_q == TC_VAL);
    cnt_d = cnt_q;
    if (i_clr || tc) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tc = tc;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between fetch and load/store; data wins; stalls the pipe.
// Latency: bus cycle starts the cycle after a request is seen; result captured on the ack edge.
// Backpressure: o_ex_stall holds the pipeline until every present request is served; bus waits on i_bus_ack, aborted after TIMEOUT.
module mem_bus_arbiter
  import rvcore_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_if_req,
  input  logic [BUS_AW-1:0] i_if_addr,
  input  logic              i_d_re,
  input  logic              i_d_we,
  input  logic [BUS_AW-1:0] i_d_addr,
  input  logic [BUS_DW-1:0] i_d_wdata,
  input  logic [STRB_W-1:0] i_d_wstrb,
  output logic [BUS_DW-1:0] o_if_inst,
  output logic [BUS_DW-1:0] o_d_rdata,
  output logic              o_ex_stall,
  output logic              o_bus_err,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [BUS_AW-1:0] o_bus_addr,
  output logic [BUS_DW-1:0] o_bus_wdata,
  output logic [STRB_W-1:0] o_bus_wstrb,
  input  logic              i_bus_ack,
  input  logic [BUS_DW-1:0] i_bus_rdata
);

  bus_state_e        state_q, state_d;
  bus_cmd_t          cmd_q, cmd_d;
  logic              d_served_q, d_served_d;
  logic              if_served_q, if_served_d;
  logic [BUS_DW-1:0] if_inst_q, if_inst_d;
  logic [BUS_DW-1:0] d_rdata_q, d_rdata_d;
  logic              bus_err_q, bus_err_d;

  logic              d_pend, if_pend, stall;
  logic              busy, ack_ok, tmo, done;
  logic [BUS_DW-1:0] cap_word;
  bus_cmd_t          d_cmd;

  // Request decode; a same-cycle request already stalls the pipeline.
  always_comb begin
    d_pend   = (i_d_re | i_d_we) & ~d_served_q;
    if_pend  = i_if_req & ~if_served_q;
    stall    = ~rst & (d_pend | if_pend);
    busy     = (state_q != ST_IDLE);
    ack_ok   = busy & i_bus_ack;
    done     = ack_ok | tmo;
    cap_word = ack_ok ? i_bus_rdata : '0;
    // Both re and we high is treated as a store.
    d_cmd.we    = i_d_we;
    d_cmd.addr  = i_d_addr;
    d_cmd.wdata = i_d_wdata;
    d_cmd.wstrb = i_d_wstrb;
  end

  // An ack in the abort cycle disables the count, so the ack wins.
  bus_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_tmo (
    .clk   (clk),
    .rst   (rst),
    .i_en  (busy & ~i_bus_ack),
    .i_clr (~busy | i_bus_ack),
    .o_tc  (tmo)
  );

  // Next-state, command latch, completion capture and served bookkeeping.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    d_served_d  = d_served_q;
    if_served_d = if_served_q;
    if_inst_d   = if_inst_q;
    d_rdata_d   = d_rdata_q;
    bus_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (d_pend) begin
          state_d = ST_DATA;
          cmd_d   = d_cmd;
        end else if (if_pend) begin
          state_d = ST_FETCH;
          cmd_d   = fetch_cmd(i_if_addr);
        end
      end
      ST_DATA: begin
        if (done) begin
          d_served_d = 1'b1;
          bus_err_d  = tmo;
          if (!cmd_q.we) begin
            d_rdata_d = cap_word;
          end
          // Chain straight into a waiting fetch without an idle cycle.
          if (if_pend) begin
            state_d = ST_FETCH;
            cmd_d   = fetch_cmd(i_if_addr);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_FETCH: begin
        if (done) begin
          if_served_d = 1'b1;
          if_inst_d   = cap_word;
          bus_err_d   = tmo;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Pipeline advances on this edge: the next instruction's requests are new.
    if (!stall) begin
      d_served_d  = 1'b0;
      if_served_d = 1'b0;
    end
  end

  // State and datapath registers; reset abandons any access silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      d_served_q  <= 1'b0;
      if_served_q <= 1'b0;
      if_inst_q   <= '0;
      d_rdata_q   <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      d_served_q  <= d_served_d;
      if_served_q <= if_served_d;
      if_inst_q   <= if_inst_d;
      d_rdata_q   <= d_rdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign o_bus_req   = busy;
  assign o_bus_we    = cmd_q.we;
  assign o_bus_addr  = cmd_q.addr;
  assign o_bus_wdata = cmd_q.wdata;
  assign o_bus_wstrb = cmd_q.wstrb;
  assign o_if_inst   = if_inst_q;
  assign o_d_rdata   = d_rdata_q;
  assign o_bus_err   = bus_err_q;
  assign o_ex_stall  = stall;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam int TB_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_if_req, i_d_re, i_d_we, i_bus_ack;
  logic [31:0] i_if_addr, i_d_addr, i_d_wdata, i_bus_rdata;
  logic [3:0]  i_d_wstrb;
  logic [31:0] o_if_inst, o_d_rdata, o_bus_addr, o_bus_wdata;
  logic [3:0]  o_bus_wstrb;
  logic        o_ex_stall, o_bus_err, o_bus_req, o_bus_we;

  mem_bus_arbiter #(.TIMEOUT(TB_TIMEOUT), .CNT_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_if_req    (i_if_req),
    .i_if_addr   (i_if_addr),
    .i_d_re      (i_d_re),
    .i_d_we      (i_d_we),
    .i_d_addr    (i_d_addr),
    .i_d_wdata   (i_d_wdata),
    .i_d_wstrb   (i_d_wstrb),
    .o_if_inst   (o_if_inst),
    .o_d_rdata   (o_d_rdata),
    .o_ex_stall  (o_ex_stall),
    .o_bus_err   (o_bus_err),
    .o_bus_req   (o_bus_req),
    .o_bus_we    (o_bus_we),
    .o_bus_addr  (o_bus_addr),
    .o_bus_wdata (o_bus_wdata),
    .o_bus_wstrb (o_bus_wstrb),
    .i_bus_ack   (i_bus_ack),
    .i_bus_rdata (i_bus_rdata)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'h00500093;
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // ---------------- bus slave ----------------
  // 0: random acks (also while idle), 1: zero-wait, 2: never, 3: ack on cycle ack_at
  int ack_mode = 2;
  int ack_at   = 1;
  int r_acc    = 0;
  bit r_prev_req = 1'b0, r_prev_ack = 1'b0;

  initial begin
    i_bus_ack   = 1'b0;
    i_bus_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (o_bus_req) begin
        if (!r_prev_req || r_prev_ack || o_bus_err) r_acc = 1;
        else r_acc++;
      end else r_acc = 0;
      case (ack_mode)
        0: begin
          i_bus_ack   = o_bus_req ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) == 0);
          i_bus_rdata = $urandom;
        end
        1: begin
          i_bus_ack   = o_bus_req;
          i_bus_rdata = mem_word(o_bus_addr);
        end
        3: begin
          i_bus_ack   = o_bus_req && (r_acc == ack_at);
          i_bus_rdata = mem_word(o_bus_addr);
        end
        default: begin
          i_bus_ack   = 1'b0;
          i_bus_rdata = 32'h0;
        end
      endcase
      r_prev_req = o_bus_req;
      r_prev_ack = i_bus_ack;
    end
  end

  // ---------------- behavioural model ----------------
  int          m_grant = 0;   // 0 none, 1 data, 2 fetch
  int          m_wcnt  = 0;   // cycles the current access has waited
  bit          m_we = 1'b0, m_dsv = 1'b0, m_ifsv = 1'b0, m_err = 1'b0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_inst = 0, m_rdata = 0;
  logic [3:0]  m_wstrb = 0;
  logic [31:0] issued_q[$];
  bit          mon_prev_req = 1'b0, mon_prev_ack = 1'b0;

  task automatic model_advance(input bit stall_now);
    bit dp, ip, tmo, fin;
    logic [31:0] word;
    if (rst) begin
      m_grant = 0; m_wcnt = 0; m_dsv = 0; m_ifsv = 0; m_err = 0;
      m_inst = 0; m_rdata = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_wstrb = 0;
      return;
    end
    dp    = (i_d_re || i_d_we) && !m_dsv;
    ip    = i_if_req && !m_ifsv;
    m_err = 1'b0;
    if (m_grant == 0) begin
      if (dp) begin
        m_grant = 1; m_wcnt = 0; m_we = i_d_we;
        m_addr = i_d_addr; m_wdata = i_d_wdata; m_wstrb = i_d_wstrb;
      end else if (ip) begin
        m_grant = 2; m_wcnt = 0; m_we = 0; m_addr = i_if_addr;
      end
    end else begin
      tmo = !i_bus_ack && (m_wcnt + 1 >= TB_TIMEOUT);
      fin = i_bus_ack || tmo;
      if (fin) begin
        word  = i_bus_ack ? i_bus_rdata : 32'h0;
        m_err = tmo;
        m_wcnt = 0;
        if (m_grant == 1) begin
          m_dsv = 1;
          if (!m_we) m_rdata = word;
          if (ip) begin m_grant = 2; m_we = 0; m_addr = i_if_addr; end
          else m_grant = 0;
        end else begin
          m_ifsv = 1; m_inst = word; m_grant = 0;
        end
      end else m_wcnt++;
    end
    if (!stall_now) begin m_dsv = 0; m_ifsv = 0; end
  endtask

  // Every-cycle comparison against the model.
  initial begin
    bit exp_stall;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_stall = !rst && (((i_d_re || i_d_we) && !m_dsv) || (i_if_req && !m_ifsv));
      chk("stall", {31'b0, o_ex_stall}, {31'b0, exp_stall});
      chk("bus_req", {31'b0, o_bus_req}, (m_grant != 0) ? 32'd1 : 32'd0);
      if (m_grant != 0) begin
        chk("bus_we", {31'b0, o_bus_we}, {31'b0, m_we});
        chk("bus_addr", o_bus_addr, m_addr);
        if (m_we) begin
          chk("bus_wdata", o_bus_wdata, m_wdata);
          chk("bus_wstrb", {28'b0, o_bus_wstrb}, {28'b0, m_wstrb});
        end
      end
      chk("if_inst", o_if_inst, m_inst);
      chk("d_rdata", o_d_rdata, m_rdata);
      chk("bus_err", {31'b0, o_bus_err}, {31'b0, m_err});
      if (o_bus_req && (!mon_prev_req || mon_prev_ack || o_bus_err)) issued_q.push_back(o_bus_addr);
      mon_prev_req = o_bus_req;
      mon_prev_ack = i_bus_ack;
      model_advance(exp_stall);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present one instruction's requests and hold them until the stall drops.
  task automatic run_instr(input int mode, input int ackat, input bit f, input logic [31:0] fa,
                           input bit re, input bit we, input logic [31:0] da,
                           input logic [31:0] wd, input logic [3:0] ws, input bit chk_cmd,
                           output int stall_cyc, output int req_cyc, output int err_cyc);
    bit done;
    ack_mode = mode;
    ack_at   = ackat;
    issued_q.delete();
    step();
    i_if_req = f; i_if_addr = fa; i_d_re = re; i_d_we = we;
    i_d_addr = da; i_d_wdata = wd; i_d_wstrb = ws;
    stall_cyc = 0; req_cyc = 0; err_cyc = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk); #1;
      if (o_ex_stall) stall_cyc++;
      if (o_bus_req)  req_cyc++;
      if (o_bus_err)  err_cyc++;
      if (chk_cmd && o_bus_req) begin
        chk("store_we", {31'b0, o_bus_we}, 32'd1);
        chk("store_addr", o_bus_addr, da);
        chk("store_wdata", o_bus_wdata, wd);
        chk("store_wstrb", {28'b0, o_bus_wstrb}, {28'b0, ws});
      end
      if (!o_ex_stall) done = 1;
      else step();
    end
    if (!done) chk("instr_budget", {31'b0, o_ex_stall}, 32'd0);
  endtask

  function automatic logic [31:0] issued_at(input int i);
    return (issued_q.size() > i) ? issued_q[i] : 32'hFFFFFFFF;
  endfunction

  initial begin
    int sc, rc, ec;
    bit f, re, we;
    int op;
    rst = 1'b1;
    i_if_req = 0; i_if_addr = 0; i_d_re = 0; i_d_we = 0;
    i_d_addr = 0; i_d_wdata = 0; i_d_wstrb = 0;
    repeat (3) step();
    @(negedge clk); #1;
    chk("rst_bus_req", {31'b0, o_bus_req}, 32'd0);
    chk("rst_stall", {31'b0, o_ex_stall}, 32'd0);
    chk("rst_err", {31'b0, o_bus_err}, 32'd0);
    chk("rst_inst", o_if_inst, 32'd0);
    chk("rst_rdata", o_d_rdata, 32'd0);
    chk("rst_addr", o_bus_addr, 32'd0);
    chk("rst_we", {31'b0, o_bus_we}, 32'd0);
    chk("rst_wdata", o_bus_wdata, 32'd0);
    chk("rst_wstrb", {28'b0, o_bus_wstrb}, 32'd0);
    step();
    rst = 1'b0;

    // Fetch only, zero-wait.
    run_instr(1, 0, 1, 32'h100, 0, 0, 0, 0, 0, 0, sc, rc, ec);
    chk("fetch_stall_cycles", sc, 2);
    chk("fetch_bus_cycles", rc, 1);
    chk("fetch_issues", issued_q.size(), 1);
    chk("fetch_addr", issued_at(0), 32'h100);
    chk("fetch_inst", o_if_inst, 32'h00500093);
    run_instr(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, sc, rc, ec);
    chk("fetch_no_reissue", rc, 0);

    // Load and fetch together: load first, fetch directly after.
    run_instr(1, 0, 1, 32'h104, 1, 0, 32'h2000, 0, 0, 0, sc, rc, ec);
    chk("both_stall_cycles", sc, 3);
    chk("both_bus_cycles", rc, 2);
    chk("both_first", issued_at(0), 32'h2000);
    chk("both_second", issued_at(1), 32'h104);
    chk("both_rdata", o_d_rdata, mem_word(32'h2000));
    chk("both_inst", o_if_inst, mem_word(32'h104));

    // Store with three wait cycles.
    run_instr(3, 4, 0, 0, 0, 1, 32'h2004, 32'hDEADBEEF, 4'b0011, 1, sc, rc, ec);
    chk("store_bus_cycles", rc, 4);
    chk("store_err", ec, 0);
    chk("store_rdata_kept", o_d_rdata, mem_word(32'h2000));

    // Load that times out.
    run_instr(2, 0, 0, 0, 1, 0, 32'h3000, 0, 0, 0, sc, rc, ec);
    chk("tmo_bus_cycles", rc, 4);
    chk("tmo_err_pulses", ec, 1);
    chk("tmo_rdata", o_d_rdata, 32'h0);

    // Ack on the last allowed cycle completes normally.
    run_instr(3, 4, 0, 0, 1, 0, 32'h3004, 0, 0, 0, sc, rc, ec);
    chk("late_bus_cycles", rc, 4);
    chk("late_err", ec, 0);
    chk("late_rdata", o_d_rdata, mem_word(32'h3004));

    // Reset during a withheld data access.
    ack_mode = 2;
    step();
    i_if_req = 0; i_d_re = 1; i_d_we = 0; i_d_addr = 32'h4000;
    @(negedge clk); #1;
    chk("rstm_c0_stall", {31'b0, o_ex_stall}, 32'd1);
    step();
    @(negedge clk); #1;
    chk("rstm_c1_req", {31'b0, o_bus_req}, 32'd1);
    step(); rst = 1'b1;
    @(negedge clk); #1;
    chk("rstm_c2_stall", {31'b0, o_ex_stall}, 32'd0);
    step();
    @(negedge clk); #1;
    chk("rstm_c3_req", {31'b0, o_bus_req}, 32'd0);
    chk("rstm_c3_stall", {31'b0, o_ex_stall}, 32'd0);
    ack_mode = 1;
    step(); rst = 1'b0;
    @(negedge clk); #1;
    chk("rstm_c4_req", {31'b0, o_bus_req}, 32'd0);
    chk("rstm_c4_stall", {31'b0, o_ex_stall}, 32'd1);
    step();
    @(negedge clk); #1;
    chk("rstm_c5_req", {31'b0, o_bus_req}, 32'd1);
    chk("rstm_c5_addr", o_bus_addr, 32'h4000);
    begin
      bit rel = 0;
      for (int c = 0; c < 20 && !rel; c++) begin
        if (!o_ex_stall) rel = 1;
        else begin step(); @(negedge clk); #1; end
      end
      chk("rstm_release", {31'b0, o_ex_stall}, 32'd0);
    end
    chk("rstm_rdata", o_d_rdata, mem_word(32'h4000));

    // Back-to-back loads.
    run_instr(1, 0, 0, 0, 1, 0, 32'h10, 0, 0, 0, sc, rc, ec);
    chk("b2b_first_issues", issued_q.size(), 1);
    chk("b2b_first_addr", issued_at(0), 32'h10);
    run_instr(1, 0, 0, 0, 1, 0, 32'h14, 0, 0, 0, sc, rc, ec);
    chk("b2b_second_issues", issued_q.size(), 1);
    chk("b2b_second_addr", issued_at(0), 32'h14);
    chk("b2b_second_stall", sc, 2);
    chk("b2b_rdata", o_d_rdata, mem_word(32'h14));

    // Randomized instruction stream with random bus latency.
    for (int n = 0; n < 300; n++) begin
      f  = ($urandom_range(0, 3) != 0);
      op = $urandom_range(0, 7);
      re = (op >= 2 && op <= 4) || (op == 7);
      we = (op == 5 || op == 6 || op == 7);
      run_instr(0, 0, f, $urandom & 32'hFFFFFFFC, re, we, $urandom & 32'hFFFFFFFC,
                $urandom, 4'($urandom_range(0, 15)), 0, sc, rc, ec);
    end

    run_instr(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, sc, rc, ec);
    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
